// File: rtl/lcu_pkg.sv
// Shared types and width helpers for the layer calculation unit row sequencer.
// Default geometry matches the LCU datapath: 8 output rows, 4-deep MAC, 2-stage DSP.
package lcu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_ISSUE,
        ST_DRAIN,
        ST_HOLD,
        ST_FIN
    } state_t;

    localparam int DEF_OP1_ROW    = 8;
    localparam int DEF_WEIGHT_ROW = 4;
    localparam int DEF_DSP_LAT    = 2;

    localparam int ADDR_W    = $clog2(DEF_WEIGHT_ROW);
    localparam int ROW_W     = (DEF_OP1_ROW > 1) ? $clog2(DEF_OP1_ROW) : 1;
    localparam int DRAIN_CYC = DEF_DSP_LAT + 1;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int row_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int drain_cycles(input int lat);
        return lat + 1;
    endfunction

    // Counter must reach the larger of the issue and drain lengths.
    function automatic int cnt_width(input int weight_row, input int lat);
        int m;
        m = (weight_row > lat + 1) ? weight_row : lat + 1;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/lcu_strobe_delay.sv
// Delay line of the issue strobe; taps feed the OP1 request and DSP enables.
// taps[0] is I1 and taps[DEPTH-1] is I(DSP_LAT+1); it shifts every cycle, never stalls.
module lcu_strobe_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic op1_req,
    output logic dsp_en,
    output logic acc_en
);

    logic [DEPTH-1:0] taps;

    always_ff @(posedge clk) begin
        if (rst) begin
            taps <= '0;
        end else begin
            taps[0] <= issue;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    // Operand arrives one cycle after issue; accumulate once it reaches the product register.
    assign op1_req = taps[0];
    assign dsp_en  = |taps;
    assign acc_en  = taps[DEPTH-1];

endmodule

// File: rtl/lcu_row_sequencer.sv
// Control FSM for the LCU: per output row clears the DSP array, issues the weight
// BRAM reads, drains the DSP pipeline and holds the result under valid/ready.
module lcu_row_sequencer
    import lcu_pkg::*;
#(
    parameter int  OP1_ROW    = DEF_OP1_ROW,
    parameter int  WEIGHT_ROW = DEF_WEIGHT_ROW,
    parameter int  DSP_LAT    = DEF_DSP_LAT,
    localparam int A_W        = addr_width(WEIGHT_ROW),
    localparam int R_W        = row_width(OP1_ROW)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic           ROW_READY,
    output logic [A_W-1:0] BRAM_ADDR,
    output logic           BRAM_RD_EN,
    output logic           OP1_REQ,
    output logic           DSP_CLR,
    output logic           DSP_EN,
    output logic           DSP_ACC_EN,
    output logic           ROW_VALID,
    output logic [R_W-1:0] ROW_IDX,
    output logic           BUSY,
    output logic           DONE
);

    localparam int CNT_W = cnt_width(WEIGHT_ROW, DSP_LAT);

    localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(WEIGHT_ROW - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(drain_cycles(DSP_LAT) - 1);
    localparam logic [R_W-1:0]   ROW_LAST   = R_W'(OP1_ROW - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [R_W-1:0]   row;
    logic [R_W-1:0]   row_nxt;
    logic             issue;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            row   <= row_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        row_nxt    = row;
        issue      = 1'b0;
        BRAM_RD_EN = 1'b0;
        BRAM_ADDR  = '0;
        DSP_CLR    = 1'b0;
        ROW_VALID  = 1'b0;
        DONE       = 1'b0;
        BUSY       = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nxt = ST_CLR;
                    row_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            ST_CLR: begin
                DSP_CLR   = 1'b1;
                state_nxt = ST_ISSUE;
                cnt_nxt   = '0;
            end
            ST_ISSUE: begin
                issue      = 1'b1;
                BRAM_RD_EN = 1'b1;
                BRAM_ADDR  = cnt[A_W-1:0];
                if (cnt == ISSUE_LAST) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                // Result stays valid until consumed; the delay line is already empty here.
                ROW_VALID = 1'b1;
                if (ROW_READY) begin
                    if (row == ROW_LAST) begin
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt = ST_CLR;
                        row_nxt   = row + R_W'(1);
                    end
                end
            end
            ST_FIN: begin
                DONE      = 1'b1;
                state_nxt = ST_IDLE;
                row_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ROW_IDX = row;

    lcu_strobe_delay #(
        .DEPTH(drain_cycles(DSP_LAT))
    ) u_strobe (
        .clk    (CLK),
        .rst    (RST),
        .issue  (issue),
        .op1_req(OP1_REQ),
        .dsp_en (DSP_EN),
        .acc_en (DSP_ACC_EN)
    );

endmodule
